sauria_cfg_sequencer: RTL and testbench

AXI4-Lite master that sequences the SAURIA accelerator's configuration. A local table of up to N_CFG register writes is loaded while idle. On a start pulse the block issues those writes in order to the accelerator's AXI4-Lite slave port, then polls a status register until a masked completion pattern appears. The block sits between the host-side control logic and the accelerator's AXI4-Lite control port, and is the sole master on that port.

---
 rtl/sauria_common_pkg.sv | 28 ++
 rtl/sauria_cfg_table.sv | 33 +++
 rtl/sauria_cfg_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_sauria_cfg_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sauria_common_pkg.sv
// Shared types and constants for the SAURIA control-path blocks.
// Holds the configuration sequencer state encoding, AXI response codes and error codes.
package sauria_common_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_POLL_AR,
        ST_POLL_R,
        ST_FINISH
    } cfg_seq_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_WRITE_RESP   = 2'd1;
    localparam logic [1:0] ERR_READ_RESP    = 2'd2;
    localparam logic [1:0] ERR_POLL_TIMEOUT = 2'd3;

    // EXOKAY is meaningless on AXI4-Lite, so anything other than OKAY is a failure.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/sauria_cfg_table.sv
// Configuration table: N_CFG entries of {register address, register data}.
// One synchronous write port, one asynchronous read port; contents are never reset.
module sauria_cfg_table #(
    parameter int N_CFG  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(N_CFG)-1:0] wr_idx,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(N_CFG)-1:0] rd_idx,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data
);
    localparam int IDX_W = $clog2(N_CFG);

    logic [ADDR_W+DATA_W-1:0] entry_reg [N_CFG];

    generate
        for (genvar gi = 0; gi < N_CFG; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (wr_idx == IDX_W'(gi))) begin
                    entry_reg[gi] <= {wr_addr, wr_data};
                end
            end
        end
    endgenerate

    assign {rd_addr, rd_data} = entry_reg[rd_idx];

endmodule

// File: rtl/sauria_cfg_sequencer.sv
// AXI4-Lite master that replays the configuration table into the accelerator,
// then polls a status register until the masked completion pattern appears.
module sauria_cfg_sequencer
    import sauria_common_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_CFG    = 16,
    parameter int POLL_MAX = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_cfg_we,
    input  logic [$clog2(N_CFG)-1:0] i_cfg_idx,
    input  logic [ADDR_W-1:0]        i_cfg_addr,
    input  logic [DATA_W-1:0]        i_cfg_data,
    input  logic [$clog2(N_CFG):0]   i_num_cfg,
    input  logic [ADDR_W-1:0]        i_poll_addr,
    input  logic [DATA_W-1:0]        i_poll_mask,
    input  logic                     i_start,
    output logic                     o_awvalid,
    input  logic                     i_awready,
    output logic [ADDR_W-1:0]        o_awaddr,
    output logic [2:0]               o_awprot,
    output logic                     o_wvalid,
    input  logic                     i_wready,
    output logic [DATA_W-1:0]        o_wdata,
    output logic [DATA_W/8-1:0]      o_wstrb,
    input  logic                     i_bvalid,
    output logic                     o_bready,
    input  logic [1:0]               i_bresp,
    output logic                     o_arvalid,
    input  logic                     i_arready,
    output logic [ADDR_W-1:0]        o_araddr,
    output logic [2:0]               o_arprot,
    input  logic                     i_rvalid,
    output logic                     o_rready,
    input  logic [DATA_W-1:0]        i_rdata,
    input  logic [1:0]               i_rresp,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [1:0]               o_err_code
);
    localparam int IDX_W  = $clog2(N_CFG);
    localparam int CNT_W  = IDX_W + 1;
    localparam int PCNT_W = $clog2(POLL_MAX + 1);

    cfg_seq_state_e    state_reg, state_next;
    logic [CNT_W-1:0]  ptr_reg, ptr_next;
    logic [CNT_W-1:0]  num_reg, num_next;
    logic [PCNT_W-1:0] poll_cnt_reg, poll_cnt_next;
    logic [ADDR_W-1:0] poll_addr_reg, poll_addr_next;
    logic [DATA_W-1:0] mask_reg, mask_next;
    logic              awvalid_reg, awvalid_next, wvalid_reg, wvalid_next;
    logic [ADDR_W-1:0] awaddr_reg, awaddr_next, araddr_reg, araddr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              bready_reg, bready_next, arvalid_reg, arvalid_next;
    logic              rready_reg, rready_next, busy_reg, busy_next;
    logic              done_reg, done_next, err_reg, err_next;
    logic [1:0]        err_code_reg, err_code_next;

    logic [CNT_W-1:0]  num_clamp;
    logic [IDX_W-1:0]  tbl_rd_idx;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;

    assign num_clamp = (i_num_cfg > CNT_W'(N_CFG)) ? CNT_W'(N_CFG) : i_num_cfg;
    // The entry needed next is always 0 at start or the one after the pointer after a B.
    assign tbl_rd_idx = (state_reg == ST_IDLE) ? '0 : ptr_reg[IDX_W-1:0] + IDX_W'(1);

    sauria_cfg_table #(
        .N_CFG  (N_CFG),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_table (
        .clk     (i_clk),
        .we      (i_cfg_we && (state_reg == ST_IDLE)),
        .wr_idx  (i_cfg_idx),
        .wr_addr (i_cfg_addr),
        .wr_data (i_cfg_data),
        .rd_idx  (tbl_rd_idx),
        .rd_addr (tbl_addr),
        .rd_data (tbl_data)
    );

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        num_next       = num_reg;
        poll_cnt_next  = poll_cnt_reg;
        poll_addr_next = poll_addr_reg;
        mask_next      = mask_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        awaddr_next    = awaddr_reg;
        wdata_next     = wdata_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        araddr_next    = araddr_reg;
        rready_next    = rready_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        err_code_next  = err_code_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    num_next       = num_clamp;
                    poll_addr_next = i_poll_addr;
                    mask_next      = i_poll_mask;
                    ptr_next       = '0;
                    poll_cnt_next  = '0;
                    err_code_next  = ERR_NONE;
                    busy_next      = 1'b1;
                    if (num_clamp != '0) begin
                        state_next   = ST_WR_REQ;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        awaddr_next  = tbl_addr;
                        wdata_next   = tbl_data;
                    end else begin
                        state_next   = ST_POLL_AR;
                        arvalid_next = 1'b1;
                        araddr_next  = i_poll_addr;
                    end
                end
            end
            ST_WR_REQ: begin
                awvalid_next = awvalid_reg && !i_awready;
                wvalid_next  = wvalid_reg && !i_wready;
                if (!awvalid_next && !wvalid_next) begin
                    state_next  = ST_WR_RSP;
                    bready_next = 1'b1;
                end
            end
            ST_WR_RSP: begin
                if (i_bvalid) begin
                    bready_next = 1'b0;
                    if (resp_is_error(i_bresp)) begin
                        state_next    = ST_FINISH;
                        busy_next     = 1'b0;
                        err_next      = 1'b1;
                        err_code_next = ERR_WRITE_RESP;
                    end else begin
                        ptr_next = ptr_reg + CNT_W'(1);
                        if (ptr_next == num_reg) begin
                            state_next   = ST_POLL_AR;
                            arvalid_next = 1'b1;
                            araddr_next  = poll_addr_reg;
                        end else begin
                            state_next   = ST_WR_REQ;
                            awvalid_next = 1'b1;
                            wvalid_next  = 1'b1;
                            awaddr_next  = tbl_addr;
                            wdata_next   = tbl_data;
                        end
                    end
                end
            end
            ST_POLL_AR: begin
                if (i_arready) begin
                    state_next   = ST_POLL_R;
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                end
            end
            ST_POLL_R: begin
                if (i_rvalid) begin
                    rready_next   = 1'b0;
                    poll_cnt_next = poll_cnt_reg + PCNT_W'(1);
                    if (resp_is_error(i_rresp)) begin
                        state_next    = ST_FINISH;
                        busy_next     = 1'b0;
                        err_next      = 1'b1;
                        err_code_next = ERR_READ_RESP;
                    end else if ((i_rdata & mask_reg) == mask_reg) begin
                        state_next = ST_FINISH;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else if (poll_cnt_next == PCNT_W'(POLL_MAX)) begin
                        state_next    = ST_FINISH;
                        busy_next     = 1'b0;
                        err_next      = 1'b1;
                        err_code_next = ERR_POLL_TIMEOUT;
                    end else begin
                        state_next   = ST_POLL_AR;
                        arvalid_next = 1'b1;
                    end
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            num_reg       <= '0;
            poll_cnt_reg  <= '0;
            poll_addr_reg <= '0;
            mask_reg      <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            awaddr_reg    <= '0;
            wdata_reg     <= '0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            araddr_reg    <= '0;
            rready_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            num_reg       <= num_next;
            poll_cnt_reg  <= poll_cnt_next;
            poll_addr_reg <= poll_addr_next;
            mask_reg      <= mask_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            awaddr_reg    <= awaddr_next;
            wdata_reg     <= wdata_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            araddr_reg    <= araddr_next;
            rready_reg    <= rready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

    assign o_awvalid  = awvalid_reg;
    assign o_awaddr   = awaddr_reg;
    assign o_awprot   = 3'b000;
    assign o_wvalid   = wvalid_reg;
    assign o_wdata    = wdata_reg;
    assign o_wstrb    = '1;
    assign o_bready   = bready_reg;
    assign o_arvalid  = arvalid_reg;
    assign o_araddr   = araddr_reg;
    assign o_arprot   = 3'b000;
    assign o_rready   = rready_reg;
    assign o_busy     = busy_reg;
    assign o_done     = done_reg;
    assign o_err      = err_reg;
    assign o_err_code = err_code_reg;

endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// Scoreboard bench for the configuration sequencer: a latency-programmable AXI4-Lite
// slave, a rule-level model filling expectation queues, and a handshake monitor.
module tb_sauria_cfg_sequencer;
    import sauria_common_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 16;
    localparam int PM = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_idx = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [4:0]    num_cfg = '0;
    logic [AW-1:0] poll_addr = '0;
    logic [DW-1:0] poll_mask = '0;
    logic          start = 1'b0;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic          bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [DW-1:0] rdata = '0;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [2:0]    awprot, arprot;
    logic          busy, done, err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    sauria_cfg_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .N_CFG(N), .POLL_MAX(PM)
    ) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .i_num_cfg(num_cfg), .i_poll_addr(poll_addr), .i_poll_mask(poll_mask), .i_start(start),
        .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awprot(awprot),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
        .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
        .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arprot(arprot),
        .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp),
        .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(err_code)
    );

    int vectors = 0;
    int miscompares = 0;

    int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    int fail_wr = -1;
    int rerr_poll = 0;
    logic [DW-1:0] poll_data [PM];
    logic [AW-1:0] tbl_addr [N];
    logic [DW-1:0] tbl_data [N];

    logic [AW-1:0] exp_aw [$];
    logic [DW-1:0] exp_w [$];
    logic [AW-1:0] exp_ar [$];
    logic [2:0]    exp_out [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: handshake seen with nothing expected", name);
    endtask

    // Slave: handshakes observed on posedge, responses driven on negedge.
    int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_wait = 0, r_wait = 0;
    int  b_pend = 0, r_pend = 0, wr_idx = 0, poll_idx = 0;
    bit  aw_got = 0, w_got = 0, bvalid_r = 0, rvalid_r = 0;
    logic [1:0]    bresp_r = 2'b00, rresp_r = 2'b00;
    logic [DW-1:0] rdata_r = '0;

    always @(posedge clk) begin
        if (!rstn) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
            b_pend = 0; r_pend = 0; aw_got = 0; w_got = 0; bvalid_r = 0; rvalid_r = 0;
        end else begin
            if (start && !busy) begin
                wr_idx = 0;
                poll_idx = 0;
            end
            if (bvalid_r && bready) begin
                check("b_for_pending_write", 64'(b_pend > 0), 64'd1);
                if (b_pend > 0) b_pend--;
                bvalid_r = 0;
                wr_idx++;
            end
            if (awvalid && awready) begin aw_got = 1; aw_cnt = 0; end
            else if (awvalid) aw_cnt++;
            if (wvalid && wready) begin w_got = 1; w_cnt = 0; end
            else if (wvalid) w_cnt++;
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend++; b_wait = b_lat;
            end
            if (b_pend > 0 && !bvalid_r) begin
                if (b_wait == 0) begin
                    bvalid_r = 1;
                    bresp_r = (wr_idx == fail_wr) ? ((wr_idx % 2 == 1) ? AXI_RESP_SLVERR : AXI_RESP_DECERR)
                                                  : AXI_RESP_OKAY;
                end else b_wait--;
            end
            if (rvalid_r && rready) begin
                rvalid_r = 0; poll_idx++;
                if (r_pend > 0) r_pend--;
            end
            if (arvalid && arready) begin ar_cnt = 0; r_pend++; r_wait = r_lat; end
            else if (arvalid) ar_cnt++;
            if (r_pend > 0 && !rvalid_r) begin
                if (r_wait == 0) begin
                    rvalid_r = 1;
                    rdata_r = (poll_idx < PM) ? poll_data[poll_idx] : '0;
                    rresp_r = (poll_idx + 1 == rerr_poll) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                end else r_wait--;
            end
        end
    end

    always @(negedge clk) begin
        awready = awvalid && (aw_cnt >= aw_lat);
        wready  = wvalid && (w_cnt >= w_lat);
        arready = arvalid && (ar_cnt >= ar_lat);
        bvalid  = bvalid_r;
        bresp   = bresp_r;
        rvalid  = rvalid_r;
        rdata   = rdata_r;
        rresp   = rresp_r;
    end

    // Monitor: pops expectations as the DUT presents handshakes and completions.
    int aw_hold = 0, w_hold = 0;
    bit prev_aw_wait = 0, prev_w_wait = 0, prev_ar_wait = 0;
    logic [AW-1:0] prev_awaddr = '0, prev_araddr = '0;
    logic [DW-1:0] prev_wdata = '0;

    always @(posedge clk) begin
        if (!rstn) begin
            aw_hold = 0; w_hold = 0;
            prev_aw_wait = 0; prev_w_wait = 0; prev_ar_wait = 0;
        end else begin
            if (prev_aw_wait) check("aw_stable", {awvalid, awaddr}, {1'b1, prev_awaddr});
            if (prev_w_wait)  check("w_stable", {wvalid, wdata}, {1'b1, prev_wdata});
            if (prev_ar_wait) check("ar_stable", {arvalid, araddr}, {1'b1, prev_araddr});
            if (awvalid) aw_hold++;
            if (wvalid) w_hold++;
            if (awvalid && awready) begin
                $display("aw addr=0x%08h", awaddr);
                if (exp_aw.size() == 0) unexp("aw");
                else check("aw_addr", awaddr, exp_aw.pop_front());
                check("aw_hold_cycles", aw_hold, aw_lat + 1);
                aw_hold = 0;
            end
            if (wvalid && wready) begin
                $display("w  data=0x%08h", wdata);
                if (exp_w.size() == 0) unexp("w");
                else check("w_data", wdata, exp_w.pop_front());
                check("w_strb", wstrb, 4'hF);
                check("w_hold_cycles", w_hold, w_lat + 1);
                w_hold = 0;
            end
            if (arvalid && arready) begin
                $display("ar addr=0x%08h", araddr);
                if (exp_ar.size() == 0) unexp("ar");
                else check("ar_addr", araddr, exp_ar.pop_front());
            end
            if (done || err) begin
                $display("end done=%0b err=%0b code=%0d", done, err, err_code);
                if (exp_out.size() == 0) unexp("completion");
                else begin
                    logic [2:0] e;
                    e = exp_out.pop_front();
                    check("outcome", {err, done, err_code}, {e[2], ~e[2], e[1:0]});
                end
            end
            prev_aw_wait = awvalid && !awready; prev_awaddr = awaddr;
            prev_w_wait  = wvalid && !wready;   prev_wdata  = wdata;
            prev_ar_wait = arvalid && !arready; prev_araddr = araddr;
        end
    end

    task automatic set_lat(input int a, input int w, input int b, input int ar, input int r);
        aw_lat = a; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
    endtask

    task automatic load(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx[3:0]; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        tbl_addr[idx] = a;
        tbl_data[idx] = d;
    endtask

    task automatic run(input int num, input int fwr, input int rerr,
                       input logic [DW-1:0] mask, input int match_at, input bit poke);
        logic [AW-1:0] pa;
        logic [DW-1:0] lsb;
        int n;
        int cyc;
        bit ended;
        pa = $urandom & ~32'h3;
        lsb = mask & (~mask + 32'd1);
        for (int p = 0; p < PM; p++) begin
            logic [DW-1:0] d;
            d = $urandom;
            if (p + 1 == match_at) d = d | mask;
            else d = d & ~lsb;
            poll_data[p] = d;
        end
        fail_wr = fwr;
        rerr_poll = rerr;
        n = (num > N) ? N : num;
        ended = 0;
        for (int i = 0; i < n && !ended; i++) begin
            exp_aw.push_back(tbl_addr[i]);
            exp_w.push_back(tbl_data[i]);
            if (i == fwr) begin exp_out.push_back({1'b1, 2'd1}); ended = 1; end
        end
        for (int p = 0; p < PM && !ended; p++) begin
            exp_ar.push_back(pa);
            if (p + 1 == rerr) begin exp_out.push_back({1'b1, 2'd2}); ended = 1; end
            else if ((poll_data[p] & mask) == mask) begin exp_out.push_back({1'b0, 2'd0}); ended = 1; end
            else if (p == PM - 1) begin exp_out.push_back({1'b1, 2'd3}); ended = 1; end
        end
        $display("run num=%0d fail_wr=%0d rerr=%0d mask=0x%08h", num, fwr, rerr, mask);
        @(negedge clk);
        num_cfg = 5'(num); poll_addr = pa; poll_mask = mask; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("valids_after_start", {awvalid, wvalid, arvalid}, (n > 0) ? 3'b110 : 3'b001);
        if (poke) begin
            @(negedge clk);
            check("busy_while_poked", busy, 1'b1);
            cfg_we = 1'b1; cfg_idx = 4'd0; cfg_addr = 32'hDEAD_BEE0; cfg_data = 32'hBAD0_BAD0;
            num_cfg = 5'd1; start = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0; start = 1'b0;
        end
        cyc = 0;
        while (exp_out.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_out.size() != 0) begin
            unexp("run_timeout");
            exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_out.delete();
        end
        repeat (3) @(negedge clk);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
        check("ar_left", exp_ar.size(), 0);
        check("idle_after_run", {busy, awvalid, wvalid, arvalid, bready, rready}, 6'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, done, err, err_code}, 10'b0);
        check("rst_addr", {awaddr, araddr}, 64'b0);
        check("rst_wdata", wdata, 32'b0);
        check("prot_strb", {awprot, arprot, wstrb}, {6'b0, 4'hF});
        rstn = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {awvalid, wvalid, bready, arvalid, rready, busy, done, err, err_code}, 10'b0);

        for (int i = 0; i < N; i++) load(i, $urandom & ~32'h3, $urandom);
        load(0, 32'h00, 32'h11);
        load(1, 32'h04, 32'h22);
        load(2, 32'h08, 32'h33);

        set_lat(0, 0, 0, 0, 0);
        run(3, -1, 0, 32'h1, 2, 0);
        set_lat(2, 0, 0, 0, 0);
        run(3, -1, 0, 32'h1, 1, 0);
        set_lat(0, 0, 0, 0, 0);
        run(3, 1, 0, 32'h1, 1, 0);
        run(0, -1, 0, 32'hF, 0, 0);
        run(2, -1, 2, 32'h80, 0, 0);
        run(1, -1, 0, 32'h0, 0, 0);
        set_lat(1, 2, 1, 1, 2);
        run(20, -1, 0, 32'h1, 1, 0);
        set_lat(0, 0, 0, 0, 0);
        run(3, -1, 0, 32'h1, 1, 1);
        run(1, -1, 0, 32'h1, 1, 0);

        set_lat(6, 6, 0, 0, 0);
        fail_wr = -1;
        rerr_poll = 0;
        @(negedge clk);
        num_cfg = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("wr_req_before_rst", {awvalid, wvalid}, 2'b11);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, done, err, err_code}, 10'b0);
        check("async_rst_data", {awaddr, wdata}, 64'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        set_lat(0, 0, 0, 0, 0);
        run(3, -1, 0, 32'h1, 1, 0);

        for (int r = 0; r < 20; r++) begin
            logic [DW-1:0] m;
            int fwr, rerr;
            set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) load($urandom_range(0, N - 1), $urandom & ~32'h3, $urandom);
            case ($urandom_range(0, 2))
                0:       m = '0;
                1:       m = 32'h1 << $urandom_range(0, 31);
                default: m = $urandom;
            endcase
            fwr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            rerr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, PM)) : 0;
            run($urandom_range(0, 20), fwr, rerr, m, $urandom_range(0, PM), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
